// File: rtl/des_pkg.sv
// DES key-schedule constants, state encoding and helper functions.
package des_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;
    localparam int unsigned COUNT_W  = 5;
    localparam int unsigned ROUND_W  = 4;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    // PC-1: CD bit i takes key bit PC1[i] (bit 1 is the MSB)
    localparam logic [6:0] PC1 [1:56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    // PC-2: subkey bit i takes CD bit PC2[i]
    localparam logic [5:0] PC2 [1:48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Per-round left-rotation amount of C and D
    localparam logic [1:0] SHIFTS [1:16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Rotate a 28-bit half toward bit 1 by 1 or 2 positions
    function automatic logic [1:28] rotl28(input logic [1:28] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
    endfunction

    // Rotate a 28-bit half toward bit 28 by 1 or 2 positions
    function automatic logic [1:28] rotr28(input logic [1:28] x, input logic [1:0] n);
        return (n == 2'd2) ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
    endfunction

    // 1 when the byte has an odd number of ones
    function automatic logic byte_odd_parity(input logic [1:8] b);
        return ^b;
    endfunction

    // 1 when any key byte has even parity
    function automatic logic key_parity_err(input logic [1:64] k);
        return !(byte_odd_parity(k[1:8])   & byte_odd_parity(k[9:16])  &
                 byte_odd_parity(k[17:24]) & byte_odd_parity(k[25:32]) &
                 byte_odd_parity(k[33:40]) & byte_odd_parity(k[41:48]) &
                 byte_odd_parity(k[49:56]) & byte_odd_parity(k[57:64]));
    endfunction

    // PC-1 permutation, used only when a key is loaded
    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] r;
        r = '0;
        for (int i = 1; i <= 56; i++) begin
            r[i] = k[PC1[i]];
        end
        return r;
    endfunction

endpackage

// File: rtl/p_box_56_48.sv
// PC-2 compression permutation: pure wiring from the CD register to a subkey.
module p_box_56_48
    import des_pkg::*;
(
    input  logic [1:56] cd,
    output logic [1:48] subkey
);

    // One wire per subkey bit, selected by the PC-2 table
    for (genvar g = 1; g <= 48; g++) begin : g_bit
        assign subkey[g] = cd[PC2[g]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule streaming K1..K16 (or K16..K1) over valid/ready.
module des_key_schedule
    import des_pkg::*;
#(
    parameter bit PARITY_CHECK = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:64] key_i,
    input  logic        decrypt_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic        abort_i,
    output logic [1:48] subkey_o,
    output logic        subkey_valid_o,
    input  logic        subkey_ready_i,
    output logic [3:0]  round_o,
    output logic        last_o,
    output logic        parity_err_o
);

    state_t             state, state_next;
    logic [COUNT_W-1:0] count, count_next;
    logic               mode, mode_next;
    logic [1:28]        c_reg, c_next;
    logic [1:28]        d_reg, d_next;
    logic               perr, perr_next;

    logic [1:56]        pc1_key;
    logic [COUNT_W-1:0] enc_idx;
    logic [COUNT_W-1:0] dec_idx;

    assign pc1_key = pc1(key_i);

    // Table index of the rotation that follows the current subkey, clamped in range
    assign enc_idx = (count >= 5'd16) ? 5'd16 : count + 5'd1;
    assign dec_idx = (count == 5'd0 || count > 5'd16) ? 5'd16 : 5'd17 - count;

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        count_next = count;
        mode_next  = mode;
        c_next     = c_reg;
        d_next     = d_reg;
        perr_next  = perr;

        if (state == IDLE) begin
            if (key_valid_i) begin
                state_next = RUN;
                count_next = 5'd1;
                mode_next  = decrypt_i;
                perr_next  = PARITY_CHECK & key_parity_err(key_i);
                // Decrypt starts from CD16, which equals the unrotated CD0
                if (decrypt_i) begin
                    c_next = pc1_key[1:28];
                    d_next = pc1_key[29:56];
                end else begin
                    c_next = rotl28(pc1_key[1:28], 2'd1);
                    d_next = rotl28(pc1_key[29:56], 2'd1);
                end
            end
        end else begin
            if (abort_i) begin
                state_next = IDLE;
            end else if (subkey_ready_i) begin
                if (count == 5'd16) begin
                    state_next = IDLE;
                end else begin
                    count_next = count + 5'd1;
                    if (mode) begin
                        c_next = rotr28(c_reg, SHIFTS[dec_idx]);
                        d_next = rotr28(d_reg, SHIFTS[dec_idx]);
                    end else begin
                        c_next = rotl28(c_reg, SHIFTS[enc_idx]);
                        d_next = rotl28(d_reg, SHIFTS[enc_idx]);
                    end
                end
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            count <= '0;
            mode  <= 1'b0;
            c_reg <= '0;
            d_reg <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            mode  <= mode_next;
            c_reg <= c_next;
            d_reg <= d_next;
            perr  <= perr_next;
        end
    end

    p_box_56_48 u_pc2 (
        .cd     ({c_reg, d_reg}),
        .subkey (subkey_o)
    );

    // Status decoded from registers only; round 16 wraps to 0 in the 4-bit
    // index and is qualified by subkey_valid_o
    assign key_ready_o    = (state == IDLE);
    assign subkey_valid_o = (state == RUN);
    assign last_o         = (state == RUN) && (count == 5'd16);
    assign round_o        = (state == RUN) ? 4'(mode ? 5'd17 - count : count) : 4'd0;
    assign parity_err_o   = perr;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule using the classic 133457799BBCDFF1 vectors.
module tb_des_key_schedule;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:64] key_i;
    logic        decrypt_i;
    logic        key_valid_i;
    logic        key_ready_o;
    logic        abort_i;
    logic [1:48] subkey_o;
    logic        subkey_valid_o;
    logic        subkey_ready_i;
    logic [3:0]  round_o;
    logic        last_o;
    logic        parity_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q [$];

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] ZKEY = 64'h0;

    // Hand-derived subkeys K1..K16 for KEY
    logic [47:0] ktab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_schedule #(.PARITY_CHECK(1'b1)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .key_i          (key_i),
        .decrypt_i      (decrypt_i),
        .key_valid_i    (key_valid_i),
        .key_ready_o    (key_ready_o),
        .abort_i        (abort_i),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .subkey_ready_i (subkey_ready_i),
        .round_o        (round_o),
        .last_o         (last_o),
        .parity_err_o   (parity_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    // Expected {pad, subkey, round, last} for the first n handshakes of a schedule
    task automatic push_sched(input bit zero, input bit dec, input int n);
        for (int i = 0; i < n; i++) begin
            int r;
            logic [47:0] k;
            r = dec ? 16 - i : i + 1;
            k = zero ? 48'd0 : ktab[r-1];
            exp_q.push_back({11'd0, k, 4'(r), (i == 15)});
        end
    endtask

    // Called at posedge+1: waits for key_ready_o, then presents one key for one edge
    task automatic send_key(input logic [63:0] k, input logic dec);
        int n = 0;
        while (!key_ready_o && n < 50) begin
            @(posedge clk_i); #1; n++;
        end
        if (!key_ready_o) fail_now("key_ready_wait");
        key_i = k;
        decrypt_i = dec;
        key_valid_i = 1'b1;
        @(posedge clk_i); #1;
        key_valid_i = 1'b0;
    endtask

    // Consume subkeys until the schedule ends; returns edges spent
    task automatic drain(input bit rnd, input int budget, output int cycles);
        cycles = 0;
        while (subkey_valid_o && cycles < budget) begin
            subkey_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk_i); #1;
            cycles++;
        end
        subkey_ready_i = 1'b0;
        if (subkey_valid_o) fail_now("drain_timeout");
    endtask

    // Run with ready high until round_o shows the target round
    task automatic run_to_round(input logic [3:0] target);
        int n = 0;
        while (round_o != target && n < 40) begin
            subkey_ready_i = 1'b1;
            @(posedge clk_i); #1;
            n++;
        end
        subkey_ready_i = 1'b0;
        if (round_o != target) fail_now("run_to_round");
    endtask

    // Monitor: pops on each handshake, checks hold while stalled
    logic        stalled = 1'b0;
    logic [47:0] held_key;
    logic [3:0]  held_round;
    always @(negedge clk_i) begin
        if (rst_i) begin
            stalled = 1'b0;
        end else if (subkey_valid_o) begin
            if (stalled) begin
                chk("stall_hold_subkey", 64'(subkey_o), 64'(held_key));
                chk("stall_hold_round", 64'(round_o), 64'(held_round));
            end
            if (subkey_ready_i && !abort_i) begin
                if (exp_q.size() == 0) fail_now("unexpected_handshake");
                else chk("handshake", {11'd0, subkey_o, round_o, last_o}, exp_q.pop_front());
                stalled = 1'b0;
            end else if (!abort_i) begin
                stalled = 1'b1;
                held_key = subkey_o;
                held_round = round_o;
            end else begin
                stalled = 1'b0;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_i = 1'b1;
        key_i = '0;
        decrypt_i = 1'b0;
        key_valid_i = 1'b0;
        abort_i = 1'b0;
        subkey_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", 64'(subkey_valid_o), 64'd0);
        chk("rst_subkey", 64'(subkey_o), 64'd0);
        chk("rst_round", 64'(round_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_parity", 64'(parity_err_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_key_ready", 64'(key_ready_o), 64'd1);

        // Encrypt, full speed
        push_sched(1'b0, 1'b0, 16);
        send_key(KEY, 1'b0);
        chk("enc_first_valid", 64'(subkey_valid_o), 64'd1);
        chk("enc_first_subkey", 64'(subkey_o), 64'h1B02EFFC7072);
        chk("enc_parity", 64'(parity_err_o), 64'd0);
        drain(1'b0, 40, cyc);
        chk("enc_cycles", 64'(cyc), 64'd16);
        chk("enc_key_ready", 64'(key_ready_o), 64'd1);
        chk("enc_queue_empty", 64'(exp_q.size()), 64'd0);

        // Decrypt, full speed
        push_sched(1'b0, 1'b1, 16);
        send_key(KEY, 1'b1);
        chk("dec_first_subkey", 64'(subkey_o), 64'hCB3D8B0E17F5);
        chk("dec_first_round", 64'(round_o), 64'(4'(16)));
        drain(1'b0, 40, cyc);
        chk("dec_queue_empty", 64'(exp_q.size()), 64'd0);

        // Random backpressure, both directions
        push_sched(1'b0, 1'b0, 16);
        send_key(KEY, 1'b0);
        drain(1'b1, 400, cyc);
        chk("bp_enc_queue_empty", 64'(exp_q.size()), 64'd0);
        push_sched(1'b0, 1'b1, 16);
        send_key(KEY, 1'b1);
        drain(1'b1, 400, cyc);
        chk("bp_dec_queue_empty", 64'(exp_q.size()), 64'd0);

        // All-zero key: parity error, zero subkeys; next good key clears it
        push_sched(1'b1, 1'b0, 16);
        send_key(ZKEY, 1'b0);
        chk("zero_parity_err", 64'(parity_err_o), 64'd1);
        drain(1'b0, 40, cyc);
        chk("zero_parity_held", 64'(parity_err_o), 64'd1);
        push_sched(1'b0, 1'b0, 16);
        send_key(KEY, 1'b0);
        chk("good_parity_clear", 64'(parity_err_o), 64'd0);
        drain(1'b0, 40, cyc);

        // Abort at round 5 together with ready
        push_sched(1'b0, 1'b0, 4);
        send_key(KEY, 1'b0);
        run_to_round(4'd5);
        abort_i = 1'b1;
        subkey_ready_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        subkey_ready_i = 1'b0;
        chk("abort_valid", 64'(subkey_valid_o), 64'd0);
        chk("abort_key_ready", 64'(key_ready_o), 64'd1);
        chk("abort_round", 64'(round_o), 64'd0);
        chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
        push_sched(1'b0, 1'b0, 16);
        send_key(KEY, 1'b0);
        chk("post_abort_round", 64'(round_o), 64'd1);
        drain(1'b0, 40, cyc);

        // Key held valid during RUN is ignored; async reset at round 9
        push_sched(1'b0, 1'b0, 8);
        send_key(KEY, 1'b0);
        key_i = ZKEY;
        key_valid_i = 1'b1;
        run_to_round(4'd9);
        chk("ignored_key_parity", 64'(parity_err_o), 64'd0);
        chk("ignored_key_subkey", 64'(subkey_o), 64'(ktab[8]));
        key_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("midrst_valid", 64'(subkey_valid_o), 64'd0);
        chk("midrst_subkey", 64'(subkey_o), 64'd0);
        chk("midrst_round", 64'(round_o), 64'd0);
        chk("midrst_last", 64'(last_o), 64'd0);
        chk("midrst_key_ready", 64'(key_ready_o), 64'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("postrst_idle", 64'(subkey_valid_o), 64'd0);
        chk("postrst_queue_empty", 64'(exp_q.size()), 64'd0);
        push_sched(1'b0, 1'b1, 16);
        send_key(KEY, 1'b1);
        drain(1'b0, 40, cyc);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
